// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 2-flop synchronizer, 5-8 data bits, optional even parity,
// 1 or 2 stop bits, single-entry output register and sticky error flags.
module uart_rx (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [2:0]  err_o,
  input  logic        err_clr_i,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, START_BIT, DATA, PARITY, STOP_BIT_FIRST, STOP_BIT_LAST} state_t;
  state_t      state_q, state_d;
  logic        sync_q, rxs_q, prev_q;
  logic [1:0]  warm_q, warm_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic        pe_q, pe_d, fe_q, fe_d, valid_q, valid_d;
  logic [2:0]  err_q, err_d;
  logic        fall, tick, last_bit, done, frame_err, good, pop;
  always_comb begin
    // edge detection is held off until the synchronizer has flushed its reset value,
    // so a line that is already low after reset never looks like a start bit
    warm_d    = warm_q + 2'(warm_q != 2'd3);
    fall      = warm_q == 2'd3 && prev_q && !rxs_q;
    tick      = cnt_q == (state_q == START_BIT ? cfg_div_i >> 1 : cfg_div_i);
    last_bit  = bit_q == {1'b0, cfg_bits_i} + 3'd4;
    state_d   = state_q;
    case (state_q)
      IDLE:           if (fall) state_d = START_BIT;
      START_BIT:      if (tick) state_d = rxs_q ? IDLE : DATA;
      DATA:           if (tick && last_bit) state_d = cfg_parity_en_i ? PARITY : STOP_BIT_FIRST;
      PARITY:         if (tick) state_d = STOP_BIT_FIRST;
      STOP_BIT_FIRST: if (tick) state_d = cfg_stop_bits_i ? STOP_BIT_LAST : IDLE;
      STOP_BIT_LAST:  if (tick) state_d = IDLE;
      default:        state_d = IDLE;
    endcase
    if (!cfg_en_i) state_d = IDLE;
    cnt_d     = (state_q == IDLE || state_d != state_q || tick) ? 16'd0 : cnt_q + 16'd1;
    bit_d     = state_q != DATA ? 3'd0 : bit_q + 3'(tick);
    shift_d   = state_q == IDLE ? 8'd0 : shift_q;
    if (state_q == DATA && tick) shift_d[bit_q] = rxs_q;
    pe_d      = state_q == IDLE ? 1'b0 : (state_q == PARITY && tick) ? ^shift_q ^ rxs_q : pe_q;
    fe_d      = state_q == IDLE ? 1'b0 : fe_q || (state_q == STOP_BIT_FIRST && tick && !rxs_q);
    done      = cfg_en_i && tick &&
                (state_q == STOP_BIT_LAST || (state_q == STOP_BIT_FIRST && !cfg_stop_bits_i));
    frame_err = fe_q || !rxs_q;
    good      = done && !frame_err && !pe_q;
    pop       = valid_q && rx_ready_i;
    valid_d   = good || (valid_q && !pop);
    data_d    = (good && (!valid_q || pop)) ? shift_q : data_q;
    err_d     = (err_clr_i ? 3'b000 : err_q) | {good && valid_q && !pop, done && frame_err, done && pe_q};
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q  <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
      warm_q  <= 2'd0;
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 3'b000;
    end else begin
      sync_q  <= rx_i;
      rxs_q   <= sync_q;
      prev_q  <= rxs_q;
      warm_q  <= warm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign err_o      = err_q;
  assign busy_o     = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks outputs against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;
  logic        clk_i = 0, rstn_i = 0, rx_i = 1, cfg_en_i = 1;
  logic [15:0] cfg_div_i = 16'd3;
  logic        cfg_parity_en_i = 0, cfg_stop_bits_i = 0, rx_ready_i = 0, err_clr_i = 0;
  logic [1:0]  cfg_bits_i = 2'd3;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, busy_o;
  logic [2:0]  err_o;
  int          n_cmp = 0, n_bad = 0, cyc = 0, rise_cyc = -1;
  logic        valid_prev = 0;
  logic [7:0]  m_data = 0;
  logic        m_valid = 0;
  logic [2:0]  m_err = 0;

  uart_rx dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .rx_i(rx_i), .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
    .cfg_parity_en_i(cfg_parity_en_i), .cfg_bits_i(cfg_bits_i), .cfg_stop_bits_i(cfg_stop_bits_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .err_o(err_o),
    .err_clr_i(err_clr_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) begin
    if (rx_valid_o && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid_o;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // a full line-level frame: start, LSB-first data, optional even parity, stop bit(s)
  task automatic send_frame(input logic [7:0] w, input bit flip, input bit bad_stop);
    int nb, per;
    logic par;
    nb = int'(cfg_bits_i) + 5;
    per = int'(cfg_div_i) + 1;
    par = flip;
    rx_i = 0;
    cycles(per);
    for (int i = 0; i < nb; i++) begin
      rx_i = w[i];
      par ^= w[i];
      cycles(per);
    end
    if (cfg_parity_en_i) begin
      rx_i = par;
      cycles(per);
    end
    for (int i = 0; i <= int'(cfg_stop_bits_i); i++) begin
      rx_i = !(bad_stop && i == int'(cfg_stop_bits_i));
      cycles(per);
    end
    rx_i = 1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 2000) begin
      cycles(1);
      n++;
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL idle_timeout: busy_o=%b required 0", busy_o); end
    cycles(3);
  endtask

  // frame-level reference: what the receiver registers must hold after one frame
  task automatic model_frame(input logic [7:0] w, input bit flip, input bit bad_stop, input bit pop_same);
    logic [8:0] mask;
    bit perr;
    mask = (9'd1 << (int'(cfg_bits_i) + 5)) - 9'd1;
    perr = flip && cfg_parity_en_i;
    if (perr) m_err[0] = 1;
    if (bad_stop) m_err[1] = 1;
    if (!perr && !bad_stop) begin
      if (m_valid && !pop_same) m_err[2] = 1;
      else begin m_data = w & mask[7:0]; m_valid = 1; end
    end
  endtask

  task automatic pop();
    rx_ready_i = 1; cycles(1); rx_ready_i = 0; m_valid = 0;
  endtask

  task automatic clr();
    err_clr_i = 1; cycles(1); err_clr_i = 0; m_err = 0;
  endtask

  function automatic int latency();
    return 4 + int'(cfg_div_i >> 1) +
           (int'(cfg_bits_i) + 5 + int'(cfg_parity_en_i) + int'(cfg_stop_bits_i) + 1) * (int'(cfg_div_i) + 1);
  endfunction

  task automatic test_reset();
    rstn_i = 0; cycles(3);
    n_cmp++; if (rx_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data_o); end
    n_cmp++; if (rx_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid_o); end
    n_cmp++; if (err_o !== 3'b000) begin n_bad++; $display("FAIL reset_err: got %b want 000", err_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    rstn_i = 1; cycles(5);
  endtask

  task automatic test_8n1();
    int c0;
    cfg_div_i = 3; cfg_bits_i = 3; cfg_parity_en_i = 0; cfg_stop_bits_i = 0;
    rise_cyc = -1; c0 = cyc;
    send_frame(8'hA5, 0, 0); wait_idle(); model_frame(8'hA5, 0, 0, 0);
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL 8n1_data: got %h want %h", rx_data_o, m_data); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL 8n1_valid: got %b want %b", rx_valid_o, m_valid); end
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL 8n1_err: got %b want %b", err_o, m_err); end
    n_cmp++; if (rise_cyc - c0 !== latency()) begin n_bad++; $display("FAIL 8n1_latency: got %0d want %0d", rise_cyc - c0, latency()); end
  endtask

  task automatic test_parity();
    pop(); clr();
    cfg_div_i = 7; cfg_bits_i = 2; cfg_parity_en_i = 1; cfg_stop_bits_i = 1;
    send_frame(8'h35, 0, 0); wait_idle(); model_frame(8'h35, 0, 0, 0);
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL 7e2_data: got %h want %h", rx_data_o, m_data); end
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL 7e2_err: got %b want %b", err_o, m_err); end
    send_frame(8'h35, 1, 0); wait_idle(); model_frame(8'h35, 1, 0, 0);
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL 7e2_parity_err: got %b want %b", err_o, m_err); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL 7e2_parity_valid: got %b want %b", rx_valid_o, m_valid); end
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL 7e2_parity_data: got %h want %h", rx_data_o, m_data); end
  endtask

  task automatic test_framing();
    pop(); clr();
    cfg_div_i = 3; cfg_bits_i = 3; cfg_parity_en_i = 0; cfg_stop_bits_i = 0;
    send_frame(8'h3C, 0, 1); wait_idle(); model_frame(8'h3C, 0, 1, 0);
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL framing_err: got %b want %b", err_o, m_err); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL framing_valid: got %b want %b", rx_valid_o, m_valid); end
    clr();
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL framing_clr: got %b want %b", err_o, m_err); end
  endtask

  task automatic test_overrun();
    int k;
    pop(); clr();
    cfg_div_i = 3; cfg_bits_i = 3; cfg_parity_en_i = 0; cfg_stop_bits_i = 0;
    send_frame(8'h11, 0, 0); wait_idle(); model_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 0, 0); wait_idle(); model_frame(8'h22, 0, 0, 0);
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL overrun_data: got %h want %h", rx_data_o, m_data); end
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL overrun_err: got %b want %b", err_o, m_err); end
    clr();
    k = latency();
    fork
      send_frame(8'h22, 0, 0);
      begin
        repeat (k - 1) @(posedge clk_i);
        #1 rx_ready_i = 1;
        @(posedge clk_i);
        #1 rx_ready_i = 0;
      end
    join
    wait_idle(); model_frame(8'h22, 0, 0, 1);
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL popsame_data: got %h want %h", rx_data_o, m_data); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL popsame_valid: got %b want %b", rx_valid_o, m_valid); end
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL popsame_err: got %b want %b", err_o, m_err); end
    pop();
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL pop_valid: got %b want %b", rx_valid_o, m_valid); end
  endtask

  task automatic test_glitch();
    pop(); clr();
    cfg_div_i = 15;
    rx_i = 0; cycles(2); rx_i = 1; cycles(2);
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL glitch_busy: got %b want 1", busy_o); end
    cycles(30);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got %b want 0", busy_o); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL glitch_valid: got %b want %b", rx_valid_o, m_valid); end
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL glitch_err: got %b want %b", err_o, m_err); end
  endtask

  task automatic test_random();
    logic [7:0] w;
    bit flip, bad;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) != 0) pop();
      if ($urandom_range(0, 1) != 0) clr();
      cfg_div_i = 16'($urandom_range(0, 9));
      cfg_bits_i = 2'($urandom_range(0, 3));
      cfg_parity_en_i = 1'($urandom_range(0, 1));
      cfg_stop_bits_i = 1'($urandom_range(0, 1));
      w = 8'($urandom);
      flip = $urandom_range(0, 3) == 0;
      bad = $urandom_range(0, 3) == 0;
      send_frame(w, flip, bad); wait_idle(); model_frame(w, flip, bad, 0);
      n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL rand%0d_data: got %h want %h", it, rx_data_o, m_data); end
      n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL rand%0d_valid: got %b want %b", it, rx_valid_o, m_valid); end
      n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL rand%0d_err: got %b want %b", it, err_o, m_err); end
    end
  endtask

  task automatic test_en_abort();
    cfg_div_i = 3; cfg_bits_i = 3; cfg_parity_en_i = 0; cfg_stop_bits_i = 0;
    send_frame(8'h77, 0, 1); wait_idle(); model_frame(8'h77, 0, 1, 0);
    cfg_div_i = 7;
    rx_i = 0; cycles(20);
    cfg_en_i = 0; cycles(1);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL en_abort_busy: got %b want 0", busy_o); end
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL en_abort_err: got %b want %b", err_o, m_err); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL en_abort_valid: got %b want %b", rx_valid_o, m_valid); end
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL en_abort_data: got %h want %h", rx_data_o, m_data); end
    rx_i = 1; cycles(3); cfg_en_i = 1; cycles(3);
  endtask

  task automatic test_reset_abort();
    cfg_div_i = 3; cfg_bits_i = 3; cfg_parity_en_i = 0; cfg_stop_bits_i = 0;
    pop();
    send_frame(8'h96, 0, 0); wait_idle(); model_frame(8'h96, 0, 0, 0);
    rx_i = 0; cycles(12);
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %b want 1", busy_o); end
    #2 rstn_i = 0;
    #1;
    m_data = 0; m_valid = 0; m_err = 0;
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL rst_abort_data: got %h want %h", rx_data_o, m_data); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL rst_abort_valid: got %b want %b", rx_valid_o, m_valid); end
    n_cmp++; if (err_o !== m_err) begin n_bad++; $display("FAIL rst_abort_err: got %b want %b", err_o, m_err); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_abort_busy: got %b want 0", busy_o); end
    cycles(2); rstn_i = 1; cycles(20);
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_low_line_busy: got %b want 0", busy_o); end
    rx_i = 1; cycles(5);
    send_frame(8'h5A, 0, 0); wait_idle(); model_frame(8'h5A, 0, 0, 0);
    n_cmp++; if (rx_data_o !== m_data) begin n_bad++; $display("FAIL rst_recover_data: got %h want %h", rx_data_o, m_data); end
    n_cmp++; if (rx_valid_o !== m_valid) begin n_bad++; $display("FAIL rst_recover_valid: got %b want %b", rx_valid_o, m_valid); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch();
    test_random();
    test_en_abort();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
  - clk_i  in  1  clock, rising edge.
  - rstn_i  in  1  reset, asynchronous, active-low.
  - rx_i  in  1  serial line, asynchronous to clk_i, idle high.
  - cfg_en_i  in  1  receiver enable.
  - cfg_div_i  in  16  bit period minus one, in clk_i cycles.
  - cfg_parity_en_i  in  1  even parity bit present after data.
  - cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
  - cfg_stop_bits_i  in  1  0=one stop bit, 1=two stop bits.
  - rx_data_o  out  8  received word, LSB-aligned, unused upper bits 0.
  - rx_valid_o  out  1  rx_data_o holds an unread word.
  - rx_ready_i  in  1  consumer accepts rx_data_o.
  - err_o  out  3  sticky errors {overrun, framing, parity}.
  - err_clr_i  in  1  clears err_o.
  - busy_o  out  1  frame reception in progress.

Function
REQ-002 rx_i SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value (rxs).
REQ-003 The FSM SHALL have the states IDLE, START_BIT, DATA, PARITY, STOP_BIT_FIRST and STOP_BIT_LAST; busy_o = (state != IDLE).
REQ-004 A 16-bit baud counter SHALL clear on every state change and in IDLE, and increment otherwise.
REQ-005 In IDLE with cfg_en_i=1, a high-to-low transition of rxs SHALL move the FSM to START_BIT.
REQ-006 In START_BIT, when counter == cfg_div_i>>1, rxs SHALL be sampled.
  - rxs=0: go to DATA.
  - rxs=1: glitch; go to IDLE with no error and no data.
REQ-007 In DATA, PARITY and STOP states, rxs SHALL be sampled when counter == cfg_div_i, i.e. every cfg_div_i+1 cycles at mid-bit.
REQ-008 Data SHALL be received LSB first; the bit count SHALL be cfg_bits_i+5. After the last data bit the FSM SHALL go to PARITY if cfg_parity_en_i=1, otherwise to STOP_BIT_FIRST.
REQ-009 Parity SHALL be even: the XOR of the data bits and the parity bit must be 0, otherwise the frame has a parity error.
REQ-010 A stop-bit sample of 0 in STOP_BIT_FIRST or STOP_BIT_LAST SHALL mark a framing error.
REQ-011 STOP_BIT_FIRST SHALL go to STOP_BIT_LAST if cfg_stop_bits_i=1, otherwise to IDLE. STOP_BIT_LAST SHALL go to IDLE.
REQ-012 A frame SHALL complete at the final stop-bit sample. On the next rising edge:
  - no error and rx_valid_o=0: rx_data_o loads the word and rx_valid_o=1.
  - parity or framing error: the word is discarded and the matching err_o bit is set.
  - no error but rx_valid_o=1: the word is discarded, rx_data_o is unchanged and err_o[2] (overrun) is set.
REQ-013 rx_valid_o SHALL clear on the edge where rx_valid_o & rx_ready_i is high. If a frame completes in that same cycle, the new word SHALL be loaded, rx_valid_o SHALL stay 1, and no overrun is flagged.
REQ-014 err_o bits SHALL stay set until err_clr_i=1; err_clr_i SHALL clear all bits. If a set event and the clear occur in the same cycle, the set SHALL win.
REQ-015 cfg_en_i=0 SHALL force the FSM to IDLE on the next edge and abort any frame in progress with no error. rx_data_o, rx_valid_o and err_o SHALL be retained.
REQ-016 Configuration inputs SHALL be treated as static while busy_o=1; changing them mid-frame gives undefined data but the FSM SHALL always return to IDLE.
REQ-017 cfg_div_i=0 SHALL give a 1-cycle bit period with the start sample at counter 0.

Reset
REQ-018 With rstn_i=0 the block SHALL set: state=IDLE, synchronizer flops=1, counter=0, rx_data_o=0x00, rx_valid_o=0, err_o=000, busy_o=0.
REQ-019 Reset assertion mid-frame SHALL abort the frame immediately. After release the block SHALL wait for a new falling edge; a line already low SHALL not start a frame.

Verification
REQ-020 cfg_div_i=3, 8N1, send 0xA5 -> rx_data_o=0xA5 and rx_valid_o=1 exactly one cycle after the stop-bit mid sample; err_o=000.
REQ-021 cfg_div_i=7, 7E2 (cfg_bits_i=10, parity and two stop bits), send 0x35 with correct parity -> rx_data_o=0x35. Resend with the parity bit flipped -> err_o=001 and rx_valid_o unchanged.
REQ-022 cfg_div_i=3, 8N1, stop bit driven 0 -> err_o=010 and no word delivered. Then err_clr_i pulse -> err_o=000.
REQ-023 Two frames 0x11 then 0x22 with rx_ready_i=0 -> rx_data_o=0x11 and err_o=100. Repeat with rx_ready_i=1 in the completion cycle of 0x22 -> rx_data_o=0x22, rx_valid_o=1, no overrun.
REQ-024 2-cycle low glitch on rx_i with cfg_div_i=15 -> FSM returns to IDLE, no valid, no error.
REQ-025 Reset and cfg_en_i abort:
  - rstn_i low in the middle of DATA -> all outputs reach their reset values immediately.
  - cfg_en_i=0 mid-frame -> busy_o=0 next cycle and err_o unchanged.
